// File: rtl/store_pkg.sv
// Shared opcodes, lane widths and byte-enable formatting for the store path.
package store_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Little-endian byte enables for a store of the given opcode at byte offset lo.
  function automatic logic [BE_W-1:0] fmt_be(input logic [5:0] op, input logic [1:0] lo);
    logic [BE_W-1:0] be;
    be = '0;
    case (op)
      OP_SB:   be = 4'b0001 << lo;
      OP_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
      OP_SW:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Places SB/SH/SW data onto the 32-bit memory lanes and flags misaligned or unknown stores.
module store_lane_fmt
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [5:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic              misaligned,
  output logic              known_op
);

  logic [BE_W-1:0] be_le;

  // Replicate the low bytes of rt across the lanes; truncation only, never sign extension.
  always_comb begin
    wdata      = '0;
    misaligned = 1'b0;
    known_op   = 1'b0;
    case (op)
      OP_SB: begin
        known_op = 1'b1;
        wdata    = {4{data[7:0]}};
      end
      OP_SH: begin
        known_op   = 1'b1;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SW: begin
        known_op   = 1'b1;
        wdata      = data;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
    be_le = fmt_be(op, addr_lo);
  end

  // Big-endian memories see byte 0 on the top lane, so the enable vector is mirrored.
  generate
    if (BIG_ENDIAN) begin : g_be
      assign be = {be_le[0], be_le[1], be_le[2], be_le[3]};
    end else begin : g_le
      assign be = be_le;
    end
  endgenerate

endmodule

// File: rtl/store_write_buffer.sv
// Store stage write buffer: formats stores, traps misalignment, queues DEPTH entries toward data memory
// and reports loads that hit a pending store word.
module store_write_buffer
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [5:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [WORD_W-1:0] st_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              misalign,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ADDR_W-3:0] e_addr [DEPTH];
  logic [WORD_W-1:0] e_data [DEPTH];
  logic [BE_W-1:0]   e_be   [DEPTH];
  logic [DEPTH-1:0]  e_vld;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic [WORD_W-1:0] f_wdata;
  logic [BE_W-1:0]   f_be;
  logic              f_mis, f_known;
  logic              accept, enq, deq;
  logic              unused_ld_lo;

  store_lane_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
    .op         (st_op),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (f_wdata),
    .be         (f_be),
    .misaligned (f_mis),
    .known_op   (f_known)
  );

  assign empty     = (count == '0);
  assign st_ready  = (count != FULL_CNT);
  assign mem_valid = !empty;
  assign accept    = st_valid & st_ready;
  assign enq       = accept & f_known & !f_mis;
  assign deq       = mem_valid & mem_ready;

  assign mem_addr  = {e_addr[rd_ptr], 2'b00};
  assign mem_wdata = e_data[rd_ptr];
  assign mem_be    = e_be[rd_ptr];

  assign unused_ld_lo = ^ld_addr[1:0];

  // Pointer/count bookkeeping; a simultaneous enqueue and dequeue leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero, valid bits track occupancy for ld_conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_be[i]   <= '0;
      end
      e_vld <= '0;
    end else begin
      if (deq) e_vld[rd_ptr] <= 1'b0;
      if (enq) begin
        e_addr[wr_ptr] <= st_addr[ADDR_W-1:2];
        e_data[wr_ptr] <= f_wdata;
        e_be[wr_ptr]   <= f_be;
        e_vld[wr_ptr]  <= 1'b1;
      end
    end
  end

  // One-cycle misalign pulse for the request accepted on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= accept & f_known & f_mis;
  end

  // Word-address match against every occupied entry, including the one leaving this cycle.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_vld[i] && (e_addr[i] == ld_addr[ADDR_W-1:2])) ld_conflict = 1'b1;
    end
  end

endmodule
